// File: rtl/darkbus_ram_resp.sv
// darkbus responder RAM: one level-held request at a time, WAIT_CYCLES wait states, one-cycle valid pulse.
// Optional DARKBUS_RESP_BOUNDS_EN: out-of-range addresses are blocked and raise a sticky err.
module darkbus_ram_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        bus_en,
    input  logic        bus_rw,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    inout  wire  [31:0] bus_data,
    output logic        bus_valid,
    output logic        err
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_rw;
    logic [AW-1:0]   r_idx;
    logic            r_oob;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_valid;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_oob;
    logic            w_wr;
    logic            w_unused;

`ifdef DARKBUS_RESP_BOUNDS_EN
    assign w_oob    = |bus_addr[31:AW+2];
    assign w_unused = ^bus_addr[1:0];
`else
    // Upper address bits are dropped so the address space wraps modulo DEPTH.
    assign w_oob    = 1'b0;
    assign w_unused = ^{bus_addr[1:0], bus_addr[31:AW+2]};
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus_en) begin
                        r_rw    <= bus_rw;
                        r_idx   <= bus_addr[AW+1:2];
                        r_oob   <= w_oob;
                        r_be    <= bus_be;
                        r_wdata <= bus_data;
                        if (WAIT_CYCLES > 0) begin
                            r_cnt   <= WAIT_INIT;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Dropping en here aborts: no write, no valid.
                    if (!bus_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_rw) r_rdata <= r_oob ? 32'hDEAD_BEEF : r_mem[r_idx];
                        if (r_oob) r_err <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= bus_en ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    if (!bus_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write commits on the ACCESS exit edge; reset on the same edge drops it.
    assign w_wr = res && (r_state == S_ACCESS) && bus_en && r_rw && !r_oob;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus_data  = (r_valid && !r_rw) ? r_rdata : 32'bz;
    assign bus_valid = r_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_darkbus_ram_resp.sv
// Bench for darkbus_ram_resp: two instances (WAIT_CYCLES 0 and 3) against a per-lane behavioural model.
module tb_darkbus_ram_resp;
    localparam int DEPTH = 1024;

    logic clk;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int ln, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %h expected %h", ln, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int W = (g == 0) ? 0 : 3;

        logic        res;
        logic        en;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic        drv;
        logic        valid;
        logic        err;
        wire  [31:0] data;

        // The initiator drives the lane except while a read request is outstanding.
        assign drv  = !(en && !rw);
        assign data = drv ? wdat : 32'bz;

        darkbus_ram_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
            .clk      (clk),
            .res      (res),
            .bus_en   (en),
            .bus_rw   (rw),
            .bus_addr (addr),
            .bus_be   (be),
            .bus_data (data),
            .bus_valid(valid),
            .err      (err)
        );

        // Behavioural model: byte-wise memory with a known-mask, request timing by edge arithmetic.
        logic [7:0]  mmem [DEPTH][4];
        bit   [3:0]  mkn  [DEPTH];
        int          k = 0;
        int          acc_k = 0;
        bit          busy = 0, resp = 0, need_low = 0;
        logic        m_rw;
        logic [31:0] m_addr, m_data;
        logic [3:0]  m_be;
        bit          exp_valid = 0, exp_rd = 0, exp_err = 0;
        logic [31:0] exp_data = 0, exp_mask = 0;
        int unsigned widx;
        bit          oob;

        always @(posedge clk) begin
            k++;
            exp_valid = 0;
            exp_rd    = 0;
            if (!res) begin
                busy = 0; resp = 0; need_low = 0; exp_err = 0;
            end else if (resp) begin
                resp     = 0;
                need_low = en;
            end else if (need_low) begin
                need_low = en;
            end else if (busy) begin
                if (!en) begin
                    busy = 0;
                end else if (k == acc_k + 1 + W) begin
                    busy      = 0;
                    resp      = 1;
                    exp_valid = 1;
                    widx = 32'((m_addr >> 2) % 32'(DEPTH));
                    oob  = 0;
`ifdef DARKBUS_RESP_BOUNDS_EN
                    oob  = (m_addr >> 2) >= 32'(DEPTH);
`endif
                    if (oob) exp_err = 1;
                    if (m_rw) begin
                        if (!oob) begin
                            for (int i = 0; i < 4; i++) begin
                                if (m_be[i]) begin
                                    mmem[widx][i] = m_data[8*i +: 8];
                                    mkn[widx][i]  = 1'b1;
                                end
                            end
                        end
                    end else begin
                        exp_rd = 1;
                        if (oob) begin
                            exp_data = 32'hDEAD_BEEF;
                            exp_mask = 32'hFFFF_FFFF;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                exp_data[8*i +: 8] = mmem[widx][i];
                                exp_mask[8*i +: 8] = {8{mkn[widx][i]}};
                            end
                        end
                    end
                end
            end else if (en) begin
                busy   = 1;
                acc_k  = k;
                m_rw   = rw;
                m_addr = addr;
                m_be   = be;
                m_data = wdat;
            end
        end

        always @(posedge clk) begin
            #1;
            check(g, "valid", 32'(valid), 32'(exp_valid));
            check(g, "err", 32'(err), 32'(exp_err));
            if (exp_valid && exp_rd)
                check(g, "rdata", data & exp_mask, exp_data & exp_mask);
            else if (drv)
                check(g, "bus_hiz", data, wdat);
        end

        task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d, input int hold,
                            output logic [31:0] rd, output int lat);
            en = 1'b1; rw = w; addr = a; be = b; wdat = w ? d : 32'h0;
            lat = 0;
            rd  = 32'h0;
            while (lat < 40) begin
                @(negedge clk);
                lat++;
                if (valid) break;
            end
            check(g, "valid_seen", 32'(valid), 32'd1);
            rd = data;
            repeat (hold) @(negedge clk);
            en = 1'b0; wdat = 32'h0;
            @(negedge clk);
        endtask

        task automatic abort(input logic w, input logic [31:0] a, input logic [31:0] d, input int n);
            en = 1'b1; rw = w; addr = a; be = 4'hF; wdat = w ? d : 32'h0;
            repeat (n) @(negedge clk);
            en = 1'b0; wdat = 32'h0;
            @(negedge clk);
        endtask

        initial begin
            logic [31:0] rd;
            logic [31:0] a;
            int          lat;
            res = 1'b0; en = 1'b0; rw = 1'b0; addr = 32'h0; be = 4'h0; wdat = 32'h0;
            repeat (3) @(negedge clk);
            check(g, "reset_valid", 32'(valid), 32'd0);
            check(g, "reset_err", 32'(err), 32'd0);
            res = 1'b1;
            @(negedge clk);

            xact(1'b1, 32'h10, 4'hF, 32'h1234_5678, 0, rd, lat);
            xact(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, lat);
            check(g, "read_latency", 32'(lat), 32'(2 + W));
            check(g, "read_full", rd, 32'h1234_5678);

            xact(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, 0, rd, lat);
            xact(1'b0, 32'h10, 4'hF, 32'h0, 2, rd, lat);
            check(g, "read_lanes", rd, 32'h12BB_56DD);
            check(g, "model_pin", {mmem[4][3], mmem[4][2], mmem[4][1], mmem[4][0]}, 32'h12BB_56DD);

            abort(1'b1, 32'h10, 32'h5555_5555, (W == 0) ? 1 : 2);
            xact(1'b0, 32'h10, 4'hF, 32'h0, 0, rd, lat);
            check(g, "after_abort", rd, 32'h12BB_56DD);

            // Reset lands on the ACCESS exit edge of a write.
            en = 1'b1; rw = 1'b1; addr = 32'h10; be = 4'hF; wdat = 32'hCAFE_F00D;
            repeat (W + 1) @(negedge clk);
            res = 1'b0;
            @(negedge clk);
            check(g, "rst_mid_valid", 32'(valid), 32'd0);
            res = 1'b1; en = 1'b0; wdat = 32'h0;
            @(negedge clk);
            xact(1'b0, 32'h10, 4'hF, 32'h0, 0, rd, lat);
            check(g, "after_reset", rd, 32'h12BB_56DD);

            xact(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 0, rd, lat);
            xact(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0, rd, lat);
            xact(1'b0, 32'h0, 4'hF, 32'h0, 0, rd, lat);
`ifdef DARKBUS_RESP_BOUNDS_EN
            check(g, "bounds_word0", rd, 32'h0BAD_F00D);
            check(g, "bounds_err", 32'(err), 32'd1);
            xact(1'b0, 32'h1000, 4'hF, 32'h0, 0, rd, lat);
            check(g, "bounds_read", rd, 32'hDEAD_BEEF);
`else
            check(g, "wrap_word0", rd, 32'hFFFF_FFFF);
            check(g, "wrap_err", 32'(err), 32'd0);
`endif

            for (int n = 0; n < 120; n++) begin
                a = {(($urandom_range(0, 5) == 0) ? 20'($urandom) : 20'h0),
                     10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                if ($urandom_range(0, 9) == 0) begin
                    abort(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, W + 1));
                end else begin
                    xact(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                         $urandom_range(0, 2), rd, lat);
                    check(g, "rand_latency", 32'(lat), 32'(2 + W));
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 30000 && done_cnt < 2; c++) @(negedge clk);
        check(0, "lanes_finished", 32'(done_cnt), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/darkbus_ram_resp.md
# darkbus_ram_resp

Single-port word-organised RAM that answers the responder end of the `darkbus` protocol driven by the core's fetch/memory bus switch. Accepts one level-held request at a time (`en`, `rw`, `addr`, `be`, `data`), services it after a programmable number of wait states, and returns a one-cycle `valid` pulse, with read data driven onto the shared tri-state `data` lane. Sits behind the datapath's bus mux in place of an ideal memory, so the stage sequencer's waiting logic is exercised with real latency.

## Interface
Parameters:
- `DEPTH`, 1024, number of 32-bit words; power of two, 2..65536; `AW = $clog2(DEPTH)`.
- `WAIT_CYCLES`, 0, wait states inserted before access; 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `res`  in  1  reset; synchronous, active-low.
- `bus.en`  in  1  request; initiator holds high with stable fields until it sees `valid`.
- `bus.rw`  in  1  1 = write (initiator drives `data`), 0 = read (this block drives `data`).
- `bus.addr`  in  32  byte address; word index `addr[AW+1:2]`, `addr[1:0]` ignored.
- `bus.be`  in  4  byte-lane enables for writes; `be[i]` covers `data[8i+7:8i]`.
- `bus.data`  inout  32  write data in; read data out; high-Z whenever not driving.
- `bus.valid`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky out-of-range flag (only with `DARKBUS_RESP_BOUNDS_EN`; tied 0 otherwise).

## Operation
- States: IDLE, WAIT, ACCESS, RESP, DONE.
- IDLE: `en`=1 at an edge latches `rw`, `addr`, `be`, `data` into request registers; go WAIT with `cnt`=`WAIT_CYCLES` if `WAIT_CYCLES`>0, else ACCESS.
- WAIT: `cnt` decrements each edge; at `cnt`==1 go ACCESS.
- ACCESS: at exit edge perform access with latched fields: write updates only lanes with `be[i]`=1 (`be`=0 is a legal no-op write); read loads full word into `rdata` (`be` ignored). Go RESP.
- RESP: `valid`=1; if latched `rw`=0, drive `rdata` on `bus.data`. Exit: `en`=1 -> DONE, `en`=0 -> IDLE.
- DONE: `valid`=0, `data` high-Z; wait for `en`=0, then IDLE. A request is never re-accepted without one `en`-low cycle in between.
- Abort: `en`=0 sampled in WAIT or ACCESS -> IDLE, no write, no `valid`.
- Request fields are latched; changes on `bus` after acceptance have no effect.

## Timing
- Reset (`res`=0 at an edge): state IDLE, `valid`=0, `data` high-Z, `cnt`=0, `rdata`=0, `err`=0; RAM contents retained; pending write dropped. Reset wins over every other event.
- Latency: request accepted at edge E; `valid` high for exactly the cycle after edge E+1+`WAIT_CYCLES` (2+`WAIT_CYCLES` cycles after the first `en`-high cycle).
- Read data valid on `bus.data` in the `valid` cycle only.
- Back-to-back: initiator drops `en` the cycle after `valid`, so the next request is accepted no earlier than 2 edges after the `valid` edge.
- Read-after-write to the same address returns the new data.

## Configuration
- `DARKBUS_RESP_BOUNDS_EN` defined: address with `addr[31:AW+2]` != 0 is out of range; writes are suppressed, reads return 32'hDEAD_BEEF, `err` sets at the ACCESS exit edge and stays set until reset. Latency is unchanged.
- Not defined: upper address bits are ignored, so the address wraps modulo `DEPTH`; `err` is constant 0.

## Test plan
- `WAIT_CYCLES`=0: write 32'h1234_5678, `be`=4'hF, to 0x10; read 0x10 -> `valid` 2 cycles after `en`, data 32'h1234_5678, `data` high-Z the next cycle.
- Byte lanes: after the previous write, write 32'hAABB_CCDD, `be`=4'b0101, to 0x10; read -> 32'h12BB_56DD.
- `WAIT_CYCLES`=3: read -> `valid` exactly 5 cycles after `en` rises; `en` held 2 extra cycles after `valid` -> no second `valid`.
- Abort and reset: drop `en` during WAIT -> no `valid`, no RAM change. Assert `res`=0 in ACCESS of a write -> `valid` never asserts, RAM unchanged, outputs at reset values.
- Bounds, `DEPTH`=1024: write 32'hFFFF_FFFF to 0x1000. With the macro defined: `err`=1; read 0x1000 -> 32'hDEAD_BEEF; word 0 unchanged. Without the macro: word 0 reads 32'hFFFF_FFFF.
